// File: rtl/serial_sub8.sv
// serial_sub8 -- bit-serial unsigned subtractor.
//   Computes a - b one bit per clock, LSB first, with a single full-subtractor
//   cell and a borrow flop. The result {borrow_out, difference} is handed back
//   through a start/busy/done handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, only looked at while idle
//   a, b   minuend / subtrahend, captured on the accepting edge
//   busy   high whenever the engine is not idle
//   done   one-cycle pulse, diff is valid
//   diff   {borrow_out, a-b} == (a - b) mod 2^(WIDTH+1)

// One full-subtractor bit cell.
module serial_sub8_fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   diff
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] res;        // result bits gathered so far, MSB = newest
    logic [WIDTH-1:0] shifted;    // res with the current bit pushed in on top
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d_bit, br_nxt;
    logic             last;

    serial_sub8_fs u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_nxt)
    );

    assign shifted = {d_bit, res};
    // Counter is exactly wide enough for 0..WIDTH-1; leaving RUN at WIDTH-1
    // means it never has to wrap.
    assign last    = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            res  <= '0;
            cnt  <= '0;
            br   <= 1'b0;
            diff <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sr <= a;
                    b_sr <= b;
                    cnt  <= '0;
                    br   <= 1'b0;
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    res  <= shifted[WIDTH-1:1];
                    br   <= br_nxt;
                    // diff is only touched on the final bit so it stays
                    // stable for the whole run.
                    if (last) diff <= {br_nxt, shifted};
                    else      cnt  <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub8.sv
// tb_serial_sub8 -- self-checking bench for serial_sub8 (WIDTH=8).
module tb_serial_sub8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W:0]   diff;

    int n_cmp = 0;
    int n_bad = 0;

    serial_sub8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain modular arithmetic on the operands.
    function automatic logic [31:0] ref_diff(input int unsigned x, input int unsigned y);
        return (x - y) & ((1 << (W + 1)) - 1);
    endfunction

    // One transaction: start for one edge (or held with new a/b when hold=1),
    // then check latency, diff stability during RUN, result and done width.
    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input bit hold);
        int n;
        int pulses;
        logic [W:0] prev;
        a = xa; b = xb; start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_rise"}, busy, 1);
        if (hold) begin a = 1; b = 1; end
        else start = 1'b0;
        prev = diff;
        n = 0;
        pulses = 0;
        while (!done && n < 40) begin
            chk({tag, "_diff_hold"}, diff, prev);
            @(posedge clk); #1;
            n++;
        end
        if (done) pulses++;
        start = 1'b0;
        chk({tag, "_latency"}, n, W);
        chk({tag, "_diff"}, diff, ref_diff(xa, xb));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
            if (k == 0) chk({tag, "_busy_fall"}, busy, 0);
        end
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_diff_kept"}, diff, ref_diff(xa, xb));
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("t1", 8'd200, 8'd45, 0);
        chk("t1_const", diff, 9'h09B);
        run_op("t2", 8'd45, 8'd200, 0);
        chk("t2_const", diff, 9'h165);
        run_op("t3a", 8'd0, 8'd1, 0);
        chk("t3a_const", diff, 9'h1FF);
        run_op("t3b", 8'd255, 8'd255, 0);
        run_op("t3c", 8'd255, 8'd0, 0);
        run_op("t3d", 8'd0, 8'd255, 0);
        run_op("t3e", 8'd0, 8'd0, 0);
        run_op("t4", 8'd200, 8'd45, 1);

        // Reset in the middle of a run
        a = 8'd77; b = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_diff", diff, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) chk("t5_no_done", {30'd0, busy, done}, 0);
        end
        run_op("t5_after", 8'd10, 8'd3, 0);

        // Random back-to-back: start held, operands change every cycle.
        begin
            logic [2*W-1:0] q[$];
            logic [2*W-1:0] op;
            int cyc = 0, acc_cyc = -100, results = 0;
            logic prev_busy = 1'b0;
            start = 1'b1;
            a = W'($urandom); b = W'($urandom);
            while (results < 1000 && cyc < 12000) begin
                @(posedge clk); #1;
                cyc++;
                if (busy && !prev_busy) begin
                    if (acc_cyc >= 0) chk("t6_spacing_ge", (cyc - acc_cyc) >= W + 2, 1);
                    acc_cyc = cyc;
                    q.push_back({a, b});
                end
                if (done) begin
                    results++;
                    if (q.size() == 0) chk("t6_spurious_done", 1, 0);
                    else begin
                        op = q.pop_front();
                        chk("t6_diff", diff, ref_diff(op[2*W-1:W], op[W-1:0]));
                        chk("t6_latency", cyc - acc_cyc, W);
                    end
                end
                prev_busy = busy;
                a = W'($urandom); b = W'($urandom);
            end
            start = 1'b0;
            chk("t6_count", results, 1000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
